// File: rtl/dmac_arb_pkg.sv
// Shared definitions for the DMA master-interface request arbiter:
// FSM state encoding, index-width helper and request-line mapping.
package dmac_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Request line 2k is channel k source, 2k+1 is channel k destination.
  function automatic int req_to_ch(input int line);
    return line / 2;
  endfunction

endpackage

// File: rtl/dmac_prio_rr_select.sv
// Combinational winner selection: highest priority among eligible lines,
// ties broken by a circular first-one search starting just after rr_ptr.
module dmac_prio_rr_select
  import dmac_arb_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int NUM_REQ = 2 * NUM_CH,
  parameter int PRIO_W  = 3,
  parameter int IDX_W   = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]       elig,
  input  logic [PRIO_W*NUM_CH-1:0] ch_prior,
  input  logic [IDX_W-1:0]         rr_ptr,
  output logic [IDX_W-1:0]         winner,
  output logic                     valid
);

  logic [PRIO_W-1:0] line_prio [NUM_REQ];
  logic [PRIO_W-1:0] max_prio;

  // Expand the per-channel priority fields onto the request lines.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      line_prio[i] = ch_prior[req_to_ch(i)*PRIO_W +: PRIO_W];
    end
  end

  // Highest priority present among the eligible lines.
  always_comb begin
    max_prio = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (elig[i] && (line_prio[i] > max_prio)) begin
        max_prio = line_prio[i];
      end
    end
  end

  // First eligible line at max_prio, scanning upward from rr_ptr+1 and
  // wrapping; rr_ptr itself is visited last so the last winner yields.
  always_comb begin : search
    int idx;
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!valid && elig[IDX_W'(idx)] && (line_prio[IDX_W'(idx)] == max_prio)) begin
        valid  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/dmac_prio_rr_arbiter.sv
// Per-master-interface request arbiter for the AHB DMA controller.
// Priority selection with round-robin among equals; grants are
// non-preemptive, lockable, and re-arbitrate with no dead cycle.
module dmac_prio_rr_arbiter
  import dmac_arb_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int NUM_REQ     = 2 * NUM_CH,
  parameter int PRIO_W      = 3,
  parameter int OUTPUT_MODE = 1,
  parameter int IDX_W       = clog2_min1(NUM_REQ)
) (
  input  logic                     hclk,
  input  logic                     hresetn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [PRIO_W*NUM_CH-1:0] ch_prior,
  input  logic [NUM_REQ-1:0]       mask,
  input  logic [NUM_REQ-1:0]       lock,
  output logic                     granted,
  output logic [NUM_REQ-1:0]       grant,
  output logic [IDX_W-1:0]         grant_index,
  output logic                     locked
);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   holder_q, holder_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] elig;
  logic [IDX_W-1:0]   sel_winner;
  logic               sel_valid;
  logic               holder_keeps;

  logic               out_granted_d;
  logic [NUM_REQ-1:0] out_grant_d;
  logic [IDX_W-1:0]   out_index_d;
  logic               out_locked_d;

  // A releasing holder is never in elig: it has either dropped req or is
  // masked without lock, so the same-cycle re-arbitration excludes it.
  assign elig = req & ~mask;

  assign holder_keeps = req[holder_q] && (!mask[holder_q] || lock[holder_q]);

  dmac_prio_rr_select #(
    .NUM_CH  (NUM_CH),
    .NUM_REQ (NUM_REQ),
    .PRIO_W  (PRIO_W),
    .IDX_W   (IDX_W)
  ) u_select (
    .elig     (elig),
    .ch_prior (ch_prior),
    .rr_ptr   (rr_ptr_q),
    .winner   (sel_winner),
    .valid    (sel_valid)
  );

  // State, holder and round-robin pointer registers.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= ARB_IDLE;
      holder_q <= '0;
      // Pointer at the top line so the first scan starts at line 0.
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q  <= state_d;
      holder_q <= holder_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state: grant from idle, hold without preemption, or hand over.
  always_comb begin
    state_d  = state_q;
    holder_d = holder_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (sel_valid) begin
          state_d  = ARB_GRANTED;
          holder_d = sel_winner;
          rr_ptr_d = sel_winner;
        end
      end
      ARB_GRANTED: begin
        if (!holder_keeps) begin
          if (sel_valid) begin
            holder_d = sel_winner;
            rr_ptr_d = sel_winner;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Output decode of the next holder; a freshly arbitrated winner is
  // unmasked, so locked can only be set on a continuing hold.
  always_comb begin
    out_granted_d = (state_d == ARB_GRANTED);
    out_grant_d   = '0;
    out_index_d   = '0;
    if (out_granted_d) begin
      out_grant_d[holder_d] = 1'b1;
      out_index_d           = holder_d;
    end
    out_locked_d = out_granted_d && mask[holder_d] && lock[holder_d];
  end

  if (OUTPUT_MODE != 0) begin : g_reg_out
    // Registered outputs, updated on the same edge as the holder.
    always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
        granted     <= 1'b0;
        grant       <= '0;
        grant_index <= '0;
        locked      <= 1'b0;
      end else begin
        granted     <= out_granted_d;
        grant       <= out_grant_d;
        grant_index <= out_index_d;
        locked      <= out_locked_d;
      end
    end
  end else begin : g_comb_out
    // Same-cycle outputs, forced low while reset is asserted.
    assign granted     = hresetn & out_granted_d;
    assign grant       = hresetn ? out_grant_d : '0;
    assign grant_index = hresetn ? out_index_d : '0;
    assign locked      = hresetn & out_locked_d;
  end

endmodule

// File: tb/tb_dmac_prio_rr_arbiter.sv
// Directed self-checking bench for dmac_prio_rr_arbiter (registered outputs).
module tb_dmac_prio_rr_arbiter;

  localparam int NUM_CH  = 8;
  localparam int NUM_REQ = 16;
  localparam int PRIO_W  = 3;
  localparam int IDX_W   = 4;

  logic                     hclk = 1'b0;
  logic                     hresetn;
  logic [NUM_REQ-1:0]       req;
  logic [PRIO_W*NUM_CH-1:0] ch_prior;
  logic [NUM_REQ-1:0]       mask;
  logic [NUM_REQ-1:0]       lock;
  logic                     granted;
  logic [NUM_REQ-1:0]       grant;
  logic [IDX_W-1:0]         grant_index;
  logic                     locked;

  typedef struct packed {
    logic               granted;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   index;
    logic               locked;
  } out_t;

  out_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  dmac_prio_rr_arbiter #(
    .NUM_CH      (NUM_CH),
    .NUM_REQ     (NUM_REQ),
    .PRIO_W      (PRIO_W),
    .OUTPUT_MODE (1),
    .IDX_W       (IDX_W)
  ) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .req         (req),
    .ch_prior    (ch_prior),
    .mask        (mask),
    .lock        (lock),
    .granted     (granted),
    .grant       (grant),
    .grant_index (grant_index),
    .locked      (locked)
  );

  always #5 hclk = ~hclk;

  // Expected output vector for holder idx (-1 = idle).
  function automatic out_t mk(input int idx, input logic lk);
    out_t o;
    o = '0;
    if (idx >= 0) begin
      o.granted = 1'b1;
      o.grant   = 16'(1) << idx;
      o.index   = 4'(idx);
    end
    o.locked = lk;
    return o;
  endfunction

  task automatic push_exp(input string tag, input int idx, input logic lk);
    exp_q.push_back(mk(idx, lk));
    tag_q.push_back(tag);
  endtask

  task automatic check();
    out_t  obs;
    out_t  exp;
    string tag;
    obs = {granted, grant, grant_index, locked};
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h, required a queued expectation", obs);
    end else begin
      exp = exp_q.pop_front();
      tag = tag_q.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: observed granted=%0b grant=%h idx=%0d locked=%0b, required granted=%0b grant=%h idx=%0d locked=%0b",
               tag, obs.granted, obs.grant, obs.index, obs.locked,
               exp.granted, exp.grant, exp.index, exp.locked);
      end
    end
  endtask

  // Queue the expectation, let one edge sample the inputs, then compare.
  task automatic step(input string tag, input int idx, input logic lk);
    push_exp(tag, idx, lk);
    @(posedge hclk);
    #1;
    check();
  endtask

  task automatic do_reset(input string tag);
    hresetn  = 1'b0;
    req      = '0;
    mask     = '0;
    lock     = '0;
    ch_prior = '0;
    #1;
    push_exp(tag, -1, 1'b0);
    check();
    @(negedge hclk);
    hresetn = 1'b1;
  endtask

  initial begin
    hresetn  = 1'b0;
    req      = '0;
    mask     = '0;
    lock     = '0;
    ch_prior = '0;
    #12;
    push_exp("reset_state", -1, 1'b0);
    check();
    @(negedge hclk);
    hresetn = 1'b1;

    // Single request, then release.
    req = 16'h0001;
    step("single_grant", 0, 1'b0);
    req = 16'h0000;
    step("single_release", -1, 1'b0);

    // Equal priority round-robin: each holder drops req for one cycle.
    do_reset("reset_rr");
    req = 16'h000F;
    step("rr_first", 0, 1'b0);
    req = 16'h000E;
    step("rr_second", 1, 1'b0);
    req = 16'h000D;
    step("rr_third", 2, 1'b0);
    req = 16'h000B;
    step("rr_fourth", 3, 1'b0);
    req = 16'h0007;
    step("rr_wrap", 0, 1'b0);
    req = 16'h000F;
    step("rr_hold", 0, 1'b0);
    req = 16'h0000;
    step("rr_idle", -1, 1'b0);

    // Channel 2 at priority 7 outranks line 0.
    ch_prior = 24'h0001C0;
    req      = 16'h0031;
    step("prio_first", 4, 1'b0);
    req = 16'h0021;
    step("prio_second", 5, 1'b0);
    req = 16'h0001;
    step("prio_low", 0, 1'b0);

    // No preemption by a higher-priority newcomer.
    ch_prior = '0;
    req      = 16'h0002;
    step("nopre_holder", 1, 1'b0);
    ch_prior = 24'h000E00;
    req      = 16'h0042;
    step("nopre_hold1", 1, 1'b0);
    step("nopre_hold2", 1, 1'b0);
    req = 16'h0040;
    step("nopre_handover", 6, 1'b0);

    // Lock keeps a masked holder; dropping lock hands over with no gap.
    ch_prior = '0;
    req      = 16'h0004;
    step("lock_holder", 2, 1'b0);
    req  = 16'h000C;
    mask = 16'h0004;
    lock = 16'h0004;
    step("lock_held1", 2, 1'b1);
    step("lock_held2", 2, 1'b1);
    lock = 16'h0000;
    step("lock_release", 3, 1'b0);

    // Asynchronous reset mid-grant, then lowest index wins first.
    #2;
    hresetn = 1'b0;
    #1;
    push_exp("async_reset", -1, 1'b0);
    check();
    req  = 16'h0006;
    mask = '0;
    lock = '0;
    @(negedge hclk);
    hresetn = 1'b1;
    step("post_reset_grant", 1, 1'b0);
    req = 16'h0000;
    step("post_reset_idle", -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
